// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: character codes, active-low segment patterns,
// anode encodings and the capture FSM state type.
package seven_seg_pkg;

    localparam int CODE_W = 5;
    typedef logic [CODE_W-1:0] code_t;

    localparam code_t CHAR_0       = 5'h00;
    localparam code_t CHAR_1       = 5'h01;
    localparam code_t CHAR_2       = 5'h02;
    localparam code_t CHAR_3       = 5'h03;
    localparam code_t CHAR_4       = 5'h04;
    localparam code_t CHAR_5       = 5'h05;
    localparam code_t CHAR_6       = 5'h06;
    localparam code_t CHAR_7       = 5'h07;
    localparam code_t CHAR_8       = 5'h08;
    localparam code_t CHAR_9       = 5'h09;
    localparam code_t CHAR_A       = 5'h0A;
    localparam code_t CHAR_B       = 5'h0B;
    localparam code_t CHAR_C       = 5'h0C;
    localparam code_t CHAR_D       = 5'h0D;
    localparam code_t CHAR_E       = 5'h0E;
    localparam code_t CHAR_F       = 5'h0F;
    localparam code_t CHAR_BLANK   = 5'h10;
    localparam code_t CHAR_UNKNOWN = 5'h1F;

    // Active-low patterns, bit 6 = segment a down to bit 0 = segment g.
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low anode enables; digit 0 is the leftmost (an[3]).
    localparam logic [3:0] AN_DIG0 = 4'b0111;
    localparam logic [3:0] AN_DIG1 = 4'b1011;
    localparam logic [3:0] AN_DIG2 = 4'b1101;
    localparam logic [3:0] AN_DIG3 = 4'b1110;
    localparam logic [3:0] AN_NONE = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } an_sel_t;

    function automatic an_sel_t an_to_sel(input logic [3:0] an);
        an_sel_t sel;
        sel = '{valid: 1'b1, idx: 2'd0};
        case (an)
            AN_DIG0: sel.idx = 2'd0;
            AN_DIG1: sel.idx = 2'd1;
            AN_DIG2: sel.idx = 2'd2;
            AN_DIG3: sel.idx = 2'd3;
            default: sel.valid = 1'b0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational active-low segment pattern to character code lookup.
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg,
    output code_t      code
);

    // "I" lights the same segments as "1", so it needs no entry of its own.
    always_comb begin
        code = CHAR_UNKNOWN;
        case (seg)
            SEG_0:     code = CHAR_0;
            SEG_1:     code = CHAR_1;
            SEG_2:     code = CHAR_2;
            SEG_3:     code = CHAR_3;
            SEG_4:     code = CHAR_4;
            SEG_5:     code = CHAR_5;
            SEG_6:     code = CHAR_6;
            SEG_7:     code = CHAR_7;
            SEG_8:     code = CHAR_8;
            SEG_9:     code = CHAR_9;
            SEG_A:     code = CHAR_A;
            SEG_B:     code = CHAR_B;
            SEG_C:     code = CHAR_C;
            SEG_D:     code = CHAR_D;
            SEG_E:     code = CHAR_E;
            SEG_F:     code = CHAR_F;
            SEG_BLANK: code = CHAR_BLANK;
            default:   code = CHAR_UNKNOWN;
        endcase
    end

endmodule

// File: rtl/seven_seg_capture.sv
// Captures the characters shown on a multiplexed 4-digit seven-segment display by
// waiting for each anode to settle, then sampling and decoding its segments.
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 400_000
) (
    input  logic       clk,
    input  logic       rst_0,
    input  logic [6:0] seg,
    input  logic [3:0] an,
    output code_t      char0,
    output code_t      char1,
    output code_t      char2,
    output code_t      char3,
    output logic [3:0] digit_valid,
    output logic       frame_valid,
    output logic       bad_pattern
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_FULL = CNT_W'(SETTLE_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_MAX     = TMO_W'(TIMEOUT_CYCLES);

    logic [6:0]       seg_s1_q, seg_s2_q;
    logic [3:0]       an_s1_q, an_s2_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    code_t [3:0]      char_q, char_d;
    logic [3:0]       dv_q, dv_d;
    logic [3:0]       seen_q, seen_d;
    logic             frame_q, frame_d;
    logic             bad_q, bad_d;
    logic             capture;
    an_sel_t          an_sel;
    code_t            dec_code;

    seven_seg_decode u_decode (
        .seg  (seg_s2_q),
        .code (dec_code)
    );

    always_comb begin
        an_sel  = an_to_sel(an_s2_q);
        capture = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (an_sel.valid) begin
                    state_d = ST_SETTLE;
                    cnt_d   = CNT_ONE;
                    idx_d   = an_sel.idx;
                end
            end
            ST_SETTLE: begin
                if (!an_sel.valid) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (an_sel.idx != idx_q) begin
                    cnt_d = CNT_ONE;
                    idx_d = an_sel.idx;
                end else if (cnt_q >= SETTLE_LAST) begin
                    capture = 1'b1;
                    state_d = ST_HOLD;
                    cnt_d   = SETTLE_FULL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (!an_sel.valid) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (an_sel.idx != idx_q) begin
                    state_d = ST_SETTLE;
                    cnt_d   = CNT_ONE;
                    idx_d   = an_sel.idx;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A capture restarts the timeout, so it wins over a timeout on the same cycle.
    always_comb begin
        char_d  = char_q;
        dv_d    = dv_q;
        seen_d  = seen_q;
        frame_d = 1'b0;
        bad_d   = 1'b0;
        tmo_d   = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
        if (capture) begin
            char_d[idx_q] = dec_code;
            dv_d[idx_q]   = 1'b1;
            bad_d         = (dec_code == CHAR_UNKNOWN);
            tmo_d         = '0;
            if (idx_q == 2'd3) begin
                frame_d = &seen_q[2:0];
                seen_d  = '0;
            end else begin
                seen_d[idx_q] = 1'b1;
            end
        end else if (tmo_q >= TMO_LAST) begin
            char_d = {4{CHAR_BLANK}};
            dv_d   = '0;
            seen_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_0) begin
            seg_s1_q <= SEG_BLANK;
            seg_s2_q <= SEG_BLANK;
            an_s1_q  <= AN_NONE;
            an_s2_q  <= AN_NONE;
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            tmo_q    <= '0;
            char_q   <= {4{CHAR_BLANK}};
            dv_q     <= '0;
            seen_q   <= '0;
            frame_q  <= 1'b0;
            bad_q    <= 1'b0;
        end else begin
            seg_s1_q <= seg;
            seg_s2_q <= seg_s1_q;
            an_s1_q  <= an;
            an_s2_q  <= an_s1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            tmo_q    <= tmo_d;
            char_q   <= char_d;
            dv_q     <= dv_d;
            seen_q   <= seen_d;
            frame_q  <= frame_d;
            bad_q    <= bad_d;
        end
    end

    assign char0       = char_q[0];
    assign char1       = char_q[1];
    assign char2       = char_q[2];
    assign char3       = char_q[3];
    assign digit_valid = dv_q;
    assign frame_valid = frame_q;
    assign bad_pattern = bad_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture: two instances (long and short timeout) share one
// stimulus stream and are compared every cycle against a run-length reference model.
`timescale 1ns/1ps
module tb_seven_seg_capture;

    localparam int SETTLE = 16;
    localparam int TMO0   = 1000;
    localparam int TMO1   = 50;

    localparam logic [6:0] P_0   = 7'b0000001;
    localparam logic [6:0] P_1   = 7'b1001111;
    localparam logic [6:0] P_2   = 7'b0010010;
    localparam logic [6:0] P_3   = 7'b0000110;
    localparam logic [6:0] P_5   = 7'b0100100;
    localparam logic [6:0] P_A   = 7'b0001000;
    localparam logic [6:0] P_E   = 7'b0110000;
    localparam logic [6:0] P_F   = 7'b0111000;
    localparam logic [6:0] P_BAD = 7'b0101010;
    localparam logic [6:0] P_OFF = 7'b1111111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_0;
    logic [6:0] seg;
    logic [3:0] an;
    logic [4:0] a_c0, a_c1, a_c2, a_c3, b_c0, b_c1, b_c2, b_c3;
    logic [3:0] a_dv, b_dv;
    logic       a_fv, b_fv, a_bad, b_bad;

    seven_seg_capture #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO0)) u_dut_a (
        .clk(clk), .rst_0(rst_0), .seg(seg), .an(an),
        .char0(a_c0), .char1(a_c1), .char2(a_c2), .char3(a_c3),
        .digit_valid(a_dv), .frame_valid(a_fv), .bad_pattern(a_bad)
    );

    seven_seg_capture #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO1)) u_dut_b (
        .clk(clk), .rst_0(rst_0), .seg(seg), .an(an),
        .char0(b_c0), .char1(b_c1), .char2(b_c2), .char3(b_c3),
        .digit_valid(b_dv), .frame_valid(b_fv), .bad_pattern(b_bad)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: code k is the index of its pattern in this list (16 = blank).
    logic [6:0] pat_tab [0:16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
        7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000, 7'b1111111};

    function automatic logic [4:0] ref_decode(input logic [6:0] s);
        for (int i = 0; i < 17; i++)
            if (pat_tab[i] == s) return 5'(i);
        return 5'h1F;
    endfunction

    function automatic int ref_digit(input logic [3:0] a);
        for (int i = 0; i < 4; i++)
            if (a == ~(4'b1000 >> i)) return i;
        return -1;
    endfunction

    function automatic int tmo_of(input int k);
        return (k == 0) ? TMO0 : TMO1;
    endfunction

    logic [3:0] m_an1, m_an2;
    logic [6:0] m_seg1, m_seg2;
    int         m_run, m_prev, m_di;
    logic       m_cap;
    logic [4:0] m_code;
    logic [4:0] m_char [2][4];
    logic [3:0] m_dv [2];
    logic [3:0] m_seen [2];
    int         m_since [2];
    logic       m_frame [2];
    logic       m_bad [2];
    logic       model_live = 1'b0;

    // Model: a digit is captured when its anode has been the same valid value for
    // exactly SETTLE consecutive synchronised cycles.
    always @(posedge clk) begin
        if (rst_0) begin
            m_an1 = 4'hF; m_an2 = 4'hF; m_seg1 = P_OFF; m_seg2 = P_OFF;
            m_run = 0; m_prev = -1;
            for (int k = 0; k < 2; k++) begin
                m_dv[k] = '0; m_seen[k] = '0; m_since[k] = 0;
                m_frame[k] = 1'b0; m_bad[k] = 1'b0;
                for (int d = 0; d < 4; d++) m_char[k][d] = 5'h10;
            end
            model_live = 1'b1;
        end else begin
            m_di = ref_digit(m_an2);
            if (m_di < 0) m_run = 0;
            else if (m_run > 0 && m_di == m_prev) begin
                if (m_run <= SETTLE) m_run++;
            end else m_run = 1;
            m_prev = m_di;
            m_cap  = (m_di >= 0) && (m_run == SETTLE);
            m_code = ref_decode(m_seg2);
            for (int k = 0; k < 2; k++) begin
                m_frame[k] = 1'b0;
                m_bad[k]   = 1'b0;
                if (m_cap) begin
                    m_char[k][m_di] = m_code;
                    m_dv[k][m_di]   = 1'b1;
                    m_bad[k]        = (m_code == 5'h1F);
                    m_since[k]      = 0;
                    if (m_di == 3) begin
                        m_frame[k] = (m_seen[k][2:0] == 3'b111);
                        m_seen[k]  = '0;
                    end else m_seen[k][m_di] = 1'b1;
                end else begin
                    if (m_since[k] < tmo_of(k)) m_since[k]++;
                    if (m_since[k] >= tmo_of(k)) begin
                        m_dv[k] = '0; m_seen[k] = '0;
                        for (int d = 0; d < 4; d++) m_char[k][d] = 5'h10;
                    end
                end
            end
            m_an2 = m_an1; m_an1 = an; m_seg2 = m_seg1; m_seg1 = seg;
        end
    end

    function automatic logic [4:0] act_char(input int k, input int d);
        logic [4:0] v;
        case (d)
            0: v = (k == 0) ? a_c0 : b_c0;
            1: v = (k == 0) ? a_c1 : b_c1;
            2: v = (k == 0) ? a_c2 : b_c2;
            default: v = (k == 0) ? a_c3 : b_c3;
        endcase
        return v;
    endfunction

    int n_fv [2]  = '{0, 0};
    int n_bad [2] = '{0, 0};

    always @(negedge clk) begin
        if (model_live) begin
            for (int k = 0; k < 2; k++) begin
                for (int d = 0; d < 4; d++)
                    chk($sformatf("u%0d.char%0d", k, d), int'(act_char(k, d)), int'(m_char[k][d]));
                chk($sformatf("u%0d.digit_valid", k), int'(k == 0 ? a_dv : b_dv), int'(m_dv[k]));
                chk($sformatf("u%0d.frame_valid", k), int'(k == 0 ? a_fv : b_fv), int'(m_frame[k]));
                chk($sformatf("u%0d.bad_pattern", k), int'(k == 0 ? a_bad : b_bad), int'(m_bad[k]));
            end
            if (a_fv) n_fv[0]++;
            if (b_fv) n_fv[1]++;
            if (a_bad) n_bad[0]++;
            if (b_bad) n_bad[1]++;
        end
    end

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".a.chars"}, int'({a_c0, a_c1, a_c2, a_c3}), int'({4{5'h10}}));
        chk({tag, ".b.chars"}, int'({b_c0, b_c1, b_c2, b_c3}), int'({4{5'h10}}));
        chk({tag, ".a.dv"}, int'(a_dv), 0);
        chk({tag, ".b.dv"}, int'(b_dv), 0);
        chk({tag, ".pulses"}, int'({a_fv, b_fv, a_bad, b_bad}), 0);
    endtask

    int base;

    initial begin
        rst_0 = 1'b1;
        an    = 4'hF;
        seg   = P_OFF;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_0 = 1'b0;
        hold(4'hF, P_OFF, 2);

        // Full slow scan F,1,A,E.
        base = n_fv[0];
        hold(4'b0111, P_F, 100);
        hold(4'b1011, P_1, 100);
        hold(4'b1101, P_A, 100);
        hold(4'b1110, P_E, 100);
        hold(4'hF, P_OFF, 5);
        chk("scan.char0", int'(a_c0), 'h0F);
        chk("scan.char1", int'(a_c1), 'h01);
        chk("scan.char2", int'(a_c2), 'h0A);
        chk("scan.char3", int'(a_c3), 'h0E);
        chk("scan.dv", int'(a_dv), 'hF);
        chk("scan.frames", n_fv[0] - base, 1);

        // Short hold, then capture on the 16th synchronised cycle.
        hold(4'b0111, P_0, 10);
        hold(4'b1011, P_2, 17);
        chk("settle.before16", int'(a_c1), 'h01);
        hold(4'b1011, P_2, 1);
        chk("settle.at16", int'(a_c1), 'h02);
        hold(4'b1011, P_2, 2);
        chk("settle.short_nocap", int'(a_c0), 'h0F);
        chk("settle.dv", int'(a_dv), 'hF);

        // Invalid anode, then a normal 16-cycle capture.
        hold(4'b0011, P_3, 10);
        chk("invalid.nocap", int'(a_c2), 'h0A);
        hold(4'b1101, P_3, 16);
        hold(4'hF, P_OFF, 4);
        chk("invalid.recapture", int'(a_c2), 'h03);

        // Unknown pattern on digit 2.
        base = n_bad[0];
        hold(4'b1101, P_BAD, 20);
        hold(4'hF, P_OFF, 4);
        chk("bad.char2", int'(a_c2), 'h1F);
        chk("bad.pulses", n_bad[0] - base, 1);

        // Fast frame, then stop: short-timeout instance clears 50 cycles after last capture.
        base = n_fv[1];
        hold(4'b0111, P_F, 20);
        hold(4'b1011, P_1, 20);
        hold(4'b1101, P_A, 20);
        hold(4'b1110, P_E, 20);
        hold(4'hF, P_OFF, 47);
        chk("tmo.frame_b", n_fv[1] - base, 1);
        chk("tmo.dv_b_49", int'(b_dv), 'hF);
        hold(4'hF, P_OFF, 1);
        chk("tmo.dv_b_50", int'(b_dv), 0);
        chk("tmo.chars_b", int'({b_c0, b_c1, b_c2, b_c3}), int'({4{5'h10}}));
        chk("tmo.dv_a_kept", int'(a_dv), 'hF);

        // Reset landing on settle cycle 15.
        an  = 4'b0111;
        seg = P_5;
        repeat (16) @(negedge clk);
        rst_0 = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midsettle");
        rst_0 = 1'b0;
        hold(4'hF, P_OFF, 5);
        chk("midsettle.nocap", int'(a_c0), 'h10);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/seven_seg_capture.md
SEVEN_SEG_CAPTURE -- requirements
Module: seven_seg_capture

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16: consecutive cycles the anode must hold one stable one-hot value before the segments are sampled.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 400_000: cycles without a completed capture before all captured state is invalidated.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_0  input  1  synchronous, active-high reset.
REQ-005 SHALL have port seg  input  7  active-low segments, seg[6]=a down to seg[0]=g.
REQ-006 SHALL have port an  input  4  active-low digit enables; an[3] is the leftmost digit (index 0).
REQ-007 SHALL have port char0..char3  output  5 each  decoded character code per digit, index 0 = leftmost.
REQ-008 SHALL have port digit_valid  output  4  bit i set once char i has been captured since reset/timeout.
REQ-009 SHALL have port frame_valid  output  1  one-cycle pulse when a full 0-1-2-3 scan completes.
REQ-010 SHALL have port bad_pattern  output  1  one-cycle pulse when a captured pattern decodes to UNKNOWN.

Function
REQ-011 SHALL register seg and an through a two-flop synchroniser before any use; all latencies count from the synchronised values.
REQ-012 SHALL map an to a digit index: 0111->0, 1011->1, 1101->2, 1110->3; any other value is invalid.
REQ-013 SHALL implement a three-state FSM: IDLE, SETTLE, HOLD.
REQ-014 SHALL go IDLE->SETTLE when the anode is valid, loading the settle counter with 1.
REQ-015 SHALL stay in SETTLE while the anode is unchanged and increment the counter each cycle.
REQ-016 SHALL capture when the counter reaches SETTLE_CYCLES: sample seg, decode it, write char[idx], set digit_valid[idx], and go to HOLD.
REQ-017 SHALL capture in every SETTLE state that ends in a capture, and only there.
REQ-018 SHALL, in SETTLE, restart SETTLE with the counter at 1 if the anode changes to another valid value; no capture occurs.
REQ-019 SHALL return to IDLE from SETTLE or HOLD if the anode becomes invalid.
REQ-020 SHALL go HOLD->SETTLE on a change to another valid anode value; HOLD never captures the same digit twice without an anode change.
REQ-021 SHALL decode seg as follows: 0-9 -> 0x00-0x09; A,b,C,d,E,F -> 0x0A-0x0F; 1111111 (blank) -> 0x10; any other pattern -> 0x1F UNKNOWN.
REQ-022 SHALL use these active-low encodings: 0=0000001, 1=1001111, A=0001000, E=0110000, F=0111000.
REQ-023 SHALL treat "I" as identical to "1" and decode it as 0x01.
REQ-024 SHALL track digits captured since the last frame_valid in a 4-bit seen mask.
REQ-025 SHALL pulse frame_valid on the cycle after capturing index 3 if seen[0..2] were all set, then clear the mask.
REQ-026 SHALL clear the seen mask without a pulse when index 3 is captured but the mask is incomplete.
REQ-027 SHALL pulse bad_pattern on the cycle after capturing an UNKNOWN code; the code is still stored.
REQ-028 SHALL run a timeout counter that resets on every capture.
REQ-029 SHALL, on reaching TIMEOUT_CYCLES, clear digit_valid and the seen mask, set all chars to 0x10, and hold the counter saturated.
REQ-030 SHALL let a capture and a timeout landing on the same cycle resolve with the capture winning.
REQ-031 SHALL keep char outputs registered, with zero combinational path from seg to the outputs.

Reset
REQ-032 SHALL, while rst_0=1 at a clock edge, force: FSM=IDLE; counters=0; char0..3=0x10; digit_valid=0; seen=0; frame_valid=0; bad_pattern=0; synchroniser flops to all-ones (blank, no digit).
REQ-033 SHALL, on reset asserted mid-SETTLE or mid-HOLD, abort the pending capture with no pulse.

Structure
REQ-034 SHALL place the character code constants (0x00-0x10, 0x1F), the anode-to-index encodings and the FSM state encoding in shared package seven_seg_pkg, also used by display drivers.
REQ-035 SHALL implement the pattern->code table as combinational sub-module seven_seg_decode (seg in, 5-bit code out), instantiated once.

Verification
REQ-036 SHALL cover: scan an=0111/1011/1101/1110 with seg=0111000/1001111/0001000/0110000, each held 100 cycles -> char0..3=0x0F,0x01,0x0A,0x0E; digit_valid=1111; one frame_valid pulse after index 3.
REQ-037 SHALL cover: anode held 10 cycles (SETTLE_CYCLES=16) -> no capture and digit_valid unchanged; next anode held 20 cycles -> capture exactly on cycle 16.
REQ-038 SHALL cover: an=0011 between digits -> IDLE, no capture; then a valid anode held 16 cycles captures normally.
REQ-039 SHALL cover: seg=0101010 captured at index 2 -> char2=0x1F and one bad_pattern pulse.
REQ-040 SHALL cover: scan stops after a full frame with TIMEOUT_CYCLES set to 50 -> after 50 cycles digit_valid=0000 and chars=0x10.
REQ-041 SHALL cover: rst_0 asserted on the settle cycle 15 -> no capture and all outputs at reset values next cycle.
